rr_pick_enc: RTL and testbench



---
 rtl/rr_pick_enc.sv | 163 ++++++++++++++++
 tb/tb_rr_pick_enc.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_pick_enc.sv
// rr_pick_enc: registered round-robin picker with binary encoder.
//
// Picks one set bit of an N-bit request vector, starting the search at a
// rotating priority pointer. The winner is presented as a one-hot vector and a
// binary index, and held behind a valid/ready handshake. A handshake moves the
// pointer one past the winner. In the same cycle the picker searches again from
// that point, so it can issue one grant per cycle. A flush drops any held grant
// without moving the pointer.
//
// Build option:
//   RR_PICK_ROUND_ROBIN_EN  defined   -> rotating priority.
//                           undefined -> pointer pinned at 0, which gives fixed
//                                        lowest-index-first priority.
//                                        Handshake, flush and latency behave
//                                        the same in both builds.

module rr_pick_enc #(
    parameter int unsigned N = 16,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] req,
    input  logic         flush,
    output logic         gnt_valid,
    input  logic         gnt_ready,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);
    localparam logic [N-1:0] ONE_N    = N'(1);

    state_t         state_q, state_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [N-1:0]   gnt_onehot_q, gnt_onehot_d;

    // Search base. In IDLE it is ptr. In GRANT it is the value ptr takes on a
    // handshake, so the back-to-back re-search already uses the advanced pointer.
    logic [W-1:0]   ptr_adv;
    logic [W-1:0]   search_base;
    logic           win_found;
    logic [W-1:0]   win_idx;
    logic [N-1:0]   win_onehot;
    int unsigned    scan_pos;
    logic [W-1:0]   scan_idx;

    // Pointer value after a handshake: one past the current winner, modulo N
    always_comb begin
        ptr_adv = '0;
`ifdef RR_PICK_ROUND_ROBIN_EN
        if (gnt_idx_q == LAST_IDX) begin
            ptr_adv = '0;
        end else begin
            ptr_adv = gnt_idx_q + W'(1);
        end
`endif
    end

    // Choose the search base for the current state
    always_comb begin
        search_base = ptr_q;
        if (state_q == GRANT) begin
            search_base = ptr_adv;
        end
    end

    // Rotating first-one search: base, base+1, ..., N-1, 0, ..., base-1
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_pos  = 0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_pos = 32'(search_base) + k;
            if (scan_pos >= N) begin
                scan_pos = scan_pos - N;
            end
            scan_idx = W'(scan_pos);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Build the one-hot winner from the index so the two always agree
    always_comb begin
        win_onehot = '0;
        if (win_found) begin
            win_onehot = ONE_N << win_idx;
        end
    end

    // Next state, next pointer and next registered grant
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;

        unique case (state_q)
            IDLE: begin
                if (!flush && win_found) begin
                    state_d      = GRANT;
                    gnt_idx_d    = win_idx;
                    gnt_onehot_d = win_onehot;
                end
            end

            GRANT: begin
                if (gnt_ready) begin
                    // The handshake always counts, even when flush is also set.
                    ptr_d = ptr_adv;
                    if (!flush && win_found) begin
                        gnt_idx_d    = win_idx;
                        gnt_onehot_d = win_onehot;
                    end else begin
                        state_d      = IDLE;
                        gnt_idx_d    = '0;
                        gnt_onehot_d = '0;
                    end
                end else if (flush) begin
                    state_d      = IDLE;
                    gnt_idx_d    = '0;
                    gnt_onehot_d = '0;
                end
            end

            default: begin
                state_d      = IDLE;
                gnt_idx_d    = '0;
                gnt_onehot_d = '0;
            end
        endcase
    end

    // State, pointer and grant registers; reset drops any grant immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
        end
    end

    assign gnt_valid  = (state_q == GRANT);
    assign gnt_onehot = gnt_onehot_q;
    assign gnt_idx    = gnt_idx_q;

endmodule

// File: tb/tb_rr_pick_enc.sv
// Testbench for rr_pick_enc with N=8.
// The reference model works at the grant level. It keeps a pointer, a
// valid flag and a winner index, and it finds winners by walking the priority
// order with modulo arithmetic.

module tb_rr_pick_enc;

    localparam int NR = 8;

    logic       clk;
    logic       resetn;
    logic [7:0] req;
    logic       flush;
    logic       gnt_valid;
    logic       gnt_ready;
    logic [7:0] gnt_onehot;
    logic [2:0] gnt_idx;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_valid;
    logic [2:0] m_idx;
    int         m_ptr;

    rr_pick_enc #(.N(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .flush      (flush),
        .gnt_valid  (gnt_valid),
        .gnt_ready  (gnt_ready),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First requester found when walking base, base+1, ... modulo 8; -1 if none
    function automatic int pick(input logic [7:0] r, input int base);
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (base + k) % NR;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic int prio_base(input int p);
`ifdef RR_PICK_ROUND_ROBIN_EN
        return p;
`else
        return 0;
`endif
    endfunction

    function automatic logic [7:0] exp_onehot();
        logic [7:0] one;
        one = 8'd1;
        return m_valid ? (one << m_idx) : 8'd0;
    endfunction

    // Advance the model by one clock edge, using the inputs seen at that edge
    task automatic model_edge(input logic [7:0] r, input logic rdy, input logic fl);
        int w;
        if (!m_valid) begin
            w = pick(r, prio_base(m_ptr));
            if (!fl && w >= 0) begin
                m_valid = 1'b1;
                m_idx   = 3'(w);
            end
        end else if (rdy) begin
`ifdef RR_PICK_ROUND_ROBIN_EN
            m_ptr = (int'(m_idx) + 1) % NR;
`endif
            w = pick(r, prio_base(m_ptr));
            if (!fl && w >= 0) begin
                m_idx = 3'(w);
            end else begin
                m_valid = 1'b0;
                m_idx   = 3'd0;
            end
        end else if (fl) begin
            m_valid = 1'b0;
            m_idx   = 3'd0;
        end
    endtask

    // Drive inputs, take one rising edge, update the model, then settle 1ns past the edge
    task automatic step(input logic [7:0] r, input logic rdy, input logic fl);
        req       = r;
        gnt_ready = rdy;
        flush     = fl;
        @(posedge clk);
        model_edge(r, rdy, fl);
        #1;
    endtask

    task automatic do_reset();
        req       = 8'd0;
        gnt_ready = 1'b0;
        flush     = 1'b0;
        resetn    = 1'b0;
        m_valid   = 1'b0;
        m_idx     = 3'd0;
        m_ptr     = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt_valid !== 1'b0 || gnt_onehot !== 8'd0 || gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b oh=%b idx=%0d, want 0/0/0", gnt_valid, gnt_onehot, gnt_idx);
        end
        for (int c = 0; c < 5; c++) begin
            step(8'h00, 1'b1, 1'b0);
            checks++;
            if (gnt_valid !== 1'b0 || gnt_onehot !== 8'd0 || gnt_idx !== 3'd0) begin
                errors++;
                $display("FAIL idle_no_req cyc %0d: got v=%b oh=%b idx=%0d, want 0/0/0", c, gnt_valid, gnt_onehot, gnt_idx);
            end
        end
    endtask

    task automatic test_rotate();
        int exp_seq[6];
`ifdef RR_PICK_ROUND_ROBIN_EN
        exp_seq = '{1, 4, 7, 1, 4, 7};
`else
        exp_seq = '{1, 1, 1, 1, 1, 1};
`endif
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(8'b1001_0010, 1'b1, 1'b0);
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'(exp_seq[c]) || gnt_onehot !== exp_onehot()
                || m_idx !== 3'(exp_seq[c])) begin
                errors++;
                $display("FAIL rotate cyc %0d: got v=%b idx=%0d oh=%b, want v=1 idx=%0d oh=%b",
                         c, gnt_valid, gnt_idx, gnt_onehot, exp_seq[c], exp_onehot());
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        step(8'b0001_0000, 1'b0, 1'b0);
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd4 || gnt_onehot !== 8'b0001_0000) begin
            errors++;
            $display("FAIL hold_first: got v=%b idx=%0d oh=%b, want v=1 idx=4", gnt_valid, gnt_idx, gnt_onehot);
        end
        for (int c = 0; c < 3; c++) begin
            step(8'b0000_0001, 1'b0, 1'b0);
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'd4 || gnt_onehot !== 8'b0001_0000) begin
                errors++;
                $display("FAIL hold_sticky cyc %0d: got v=%b idx=%0d oh=%b, want v=1 idx=4", c, gnt_valid, gnt_idx, gnt_onehot);
            end
        end
        step(8'b0000_0001, 1'b1, 1'b0);
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0 || gnt_onehot !== 8'b0000_0001) begin
            errors++;
            $display("FAIL hold_wrap: got v=%b idx=%0d oh=%b, want v=1 idx=0", gnt_valid, gnt_idx, gnt_onehot);
        end
        step(8'b0000_0000, 1'b1, 1'b0);
        checks++;
        if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || gnt_onehot !== 8'd0) begin
            errors++;
            $display("FAIL hold_drain: got v=%b idx=%0d oh=%b, want 0/0/0", gnt_valid, gnt_idx, gnt_onehot);
        end
    endtask

    task automatic test_flush();
        do_reset();
        step(8'b0000_1000, 1'b0, 1'b0);
        step(8'b0000_1000, 1'b0, 1'b1);
        checks++;
        if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || gnt_onehot !== 8'd0) begin
            errors++;
            $display("FAIL flush_no_hs: got v=%b idx=%0d oh=%b, want 0/0/0", gnt_valid, gnt_idx, gnt_onehot);
        end
        step(8'b0000_1000, 1'b0, 1'b0);
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3 || gnt_onehot !== 8'b0000_1000) begin
            errors++;
            $display("FAIL flush_regrant: got v=%b idx=%0d oh=%b, want v=1 idx=3", gnt_valid, gnt_idx, gnt_onehot);
        end
    endtask

    task automatic test_flush_handshake();
        logic [2:0] exp_next;
`ifdef RR_PICK_ROUND_ROBIN_EN
        exp_next = 3'd7;
`else
        exp_next = 3'd0;
`endif
        do_reset();
        step(8'b0100_0000, 1'b0, 1'b0);
        step(8'hFF, 1'b1, 1'b1);
        checks++;
        if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || gnt_onehot !== 8'd0) begin
            errors++;
            $display("FAIL flush_hs_clear: got v=%b idx=%0d oh=%b, want 0/0/0", gnt_valid, gnt_idx, gnt_onehot);
        end
        step(8'hFF, 1'b0, 1'b0);
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== exp_next || gnt_idx !== m_idx || gnt_onehot !== exp_onehot()) begin
            errors++;
            $display("FAIL flush_hs_next: got v=%b idx=%0d oh=%b, want v=1 idx=%0d", gnt_valid, gnt_idx, gnt_onehot, exp_next);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(8'b0010_0100, 1'b0, 1'b0);
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2) begin
            errors++;
            $display("FAIL areset_setup: got v=%b idx=%0d, want v=1 idx=2", gnt_valid, gnt_idx);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || gnt_onehot !== 8'd0) begin
            errors++;
            $display("FAIL areset_async: got v=%b idx=%0d oh=%b, want 0/0/0", gnt_valid, gnt_idx, gnt_onehot);
        end
        m_valid = 1'b0;
        m_idx   = 3'd0;
        m_ptr   = 0;
        @(negedge clk);
        resetn = 1'b1;
        step(8'b1000_0100, 1'b0, 1'b0);
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2 || gnt_onehot !== 8'b0000_0100) begin
            errors++;
            $display("FAIL areset_ptr0: got v=%b idx=%0d oh=%b, want v=1 idx=2", gnt_valid, gnt_idx, gnt_onehot);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [7:0] r;
            logic       rdy;
            logic       fl;
            r   = 8'($urandom) & 8'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            step(r, rdy, fl);
            checks++;
            if (gnt_valid !== m_valid || gnt_idx !== m_idx || gnt_onehot !== exp_onehot()) begin
                errors++;
                $display("FAIL random cyc %0d: got v=%b idx=%0d oh=%b, want v=%b idx=%0d oh=%b",
                         c, gnt_valid, gnt_idx, gnt_onehot, m_valid, m_idx, exp_onehot());
            end
        end
    endtask

    initial begin
        resetn    = 1'b0;
        req       = 8'd0;
        flush     = 1'b0;
        gnt_ready = 1'b0;
        test_reset();
        test_rotate();
        test_hold();
        test_flush();
        test_flush_handshake();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
